// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode constants, fetch-stage state encoding
// and a small helper for recognising the NOOP word.
package cpu_defs_pkg;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLT = 6'b100010;
  localparam logic [5:0] OP_BLE = 6'b100011;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  // A NOOP is the all-zero word: NOP opcode with every operand field clear.
  function automatic logic is_nop(input logic [31:0] instr);
    return (instr[31:26] == OP_NOP) && (instr[25:0] == 26'd0);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection for a retiring instruction.
// Redirect targets are relative to the instruction's own PC plus one;
// a jump takes priority over a taken branch.
module pc_target_calc
  import cpu_defs_pkg::*;
(
  input  logic [31:0] ir_pc,
  input  logic [15:0] br_off,
  input  logic [25:0] jmp_off,
  input  logic        br_taken,
  input  logic        jmp,
  input  logic [31:0] pc_out,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign seq_pc     = ir_pc + 32'd1;
  assign br_target  = seq_pc + {{16{br_off[15]}}, br_off};
  assign jmp_target = seq_pc + {{6{jmp_off[25]}}, jmp_off};

  // Choose the redirect target, or keep the already-incremented PC.
  always_comb begin
    next_pc = pc_out;
    if (jmp) begin
      next_pc = jmp_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle CPU: owns the PC, latches the IMem word
// into the IR, redirects on jump/branch at retirement, halts on NOOP and
// counts retired instructions.
module instr_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          HALT_ON_NOP = 1,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic [31:0]      instr_in,
  input  logic             ir_done,
  input  logic             br_taken,
  input  logic [15:0]      br_off,
  input  logic             jmp,
  input  logic [25:0]      jmp_off,
  output logic [31:0]      pc_out,
  output logic [31:0]      ir_out,
  output logic [31:0]      ir_pc,
  output logic             ir_valid,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  next_pc;
  logic         halt_fetch;

  assign halt_fetch = (HALT_ON_NOP != 0) && is_nop(instr_in);
  assign halted     = (state == S_HALT);

  pc_target_calc u_pc_target (
    .ir_pc    (ir_pc),
    .br_off   (br_off),
    .jmp_off  (jmp_off),
    .br_taken (br_taken),
    .jmp      (jmp),
    .pc_out   (pc_out),
    .next_pc  (next_pc)
  );

  // State register; reset returns to fetch from anywhere, even mid-instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fetch -> hold until retirement, or fetch -> halt on NOOP.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (fetch_en) state_next = halt_fetch ? S_HALT : S_HOLD;
      S_HOLD:  if (ir_done)  state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // PC, IR and retirement counter updates; everything freezes once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out      <= RESET_PC;
      ir_out      <= 32'd0;
      ir_pc       <= 32'd0;
      ir_valid    <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_en) begin
            ir_out   <= instr_in;
            ir_pc    <= pc_out;
            ir_valid <= 1'b1;
            pc_out   <= pc_out + 32'd1;
          end
        end
        S_HOLD: begin
          if (ir_done) begin
            ir_valid    <= 1'b0;
            instr_count <= instr_count + CNT_W'(1);
            pc_out      <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a reference model predicts every
// cycle, predictions are queued when stimulus is driven and compared after the edge.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] instr_in;
  logic        ir_done;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jmp;
  logic [25:0] jmp_off;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [31:0] instr_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] irpc;
    logic        valid;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state (0 = fetch, 1 = hold, 2 = halt)
  logic [31:0] m_pc, m_ir, m_irpc, m_cnt;
  logic        m_valid;
  int          m_state;

  instr_fetch_unit #(
    .RESET_PC    (32'd0),
    .HALT_ON_NOP (1),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .instr_in    (instr_in),
    .ir_done     (ir_done),
    .br_taken    (br_taken),
    .br_off      (br_off),
    .jmp         (jmp),
    .jmp_off     (jmp_off),
    .pc_out      (pc_out),
    .ir_out      (ir_out),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance the reference model by one clock given the driven inputs.
  task automatic modelStep(input logic r, input logic fe, input logic [31:0] ins,
                           input logic done, input logic br, input logic [15:0] bo,
                           input logic j, input logic [25:0] jo);
    if (r) begin
      m_pc = 32'd0; m_ir = 32'd0; m_irpc = 32'd0;
      m_valid = 1'b0; m_cnt = 32'd0; m_state = 0;
    end else if (m_state == 0) begin
      if (fe) begin
        m_ir = ins; m_irpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd1;
        m_state = (ins == 32'd0) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      if (done) begin
        m_valid = 1'b0; m_cnt = m_cnt + 32'd1; m_state = 0;
        if (j)       m_pc = m_irpc + 32'd1 + {{6{jo[25]}}, jo};
        else if (br) m_pc = m_irpc + 32'd1 + {{16{bo[15]}}, bo};
      end
    end
  endtask

  // Drive one cycle of inputs, queue the prediction, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic fe, input logic [31:0] ins,
                               input logic done, input logic br, input logic [15:0] bo,
                               input logic j, input logic [25:0] jo);
    exp_t e;
    rst = r; fetch_en = fe; instr_in = ins; ir_done = done;
    br_taken = br; br_off = bo; jmp = j; jmp_off = jo;
    modelStep(r, fe, ins, done, br, bo, j, jo);
    e.pc = m_pc; e.ir = m_ir; e.irpc = m_irpc; e.valid = m_valid;
    e.halt = (m_state == 2); e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("pc_out", pc_out, e.pc);
    checkOutput("ir_out", ir_out, e.ir);
    checkOutput("ir_pc", ir_pc, e.irpc);
    checkOutput("ir_valid", {31'd0, ir_valid}, {31'd0, e.valid});
    checkOutput("halted", {31'd0, halted}, {31'd0, e.halt});
    checkOutput("instr_count", instr_count, e.cnt);
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_irpc = 0; m_cnt = 0; m_valid = 0; m_state = 0;
    rst = 1'b1; fetch_en = 1'b0; instr_in = 32'd0; ir_done = 1'b0;
    br_taken = 1'b0; br_off = 16'd0; jmp = 1'b0; jmp_off = 26'd0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 32'h0, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("reset_pc", pc_out, 32'd0);
    checkOutput("reset_valid", {31'd0, ir_valid}, 32'd0);

    // Retirement controls are ignored while fetching
    applyStimulus(0, 0, 32'h0, 1, 1, 16'h0005, 1, 26'h5);

    // Fetch an LI word at PC 0
    applyStimulus(0, 1, 32'h2C01_0005, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("t1_ir", ir_out, 32'h2C01_0005);
    checkOutput("t1_pc", pc_out, 32'd1);

    // fetch_en in hold must not touch the IR
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("hold_ir", ir_out, 32'h2C01_0005);

    // Jump forward to 12
    applyStimulus(0, 0, 32'h0, 1, 0, 16'h0, 1, 26'd11);
    checkOutput("jmp12_pc", pc_out, 32'd12);

    // BNE at 12 taken backwards by 3
    applyStimulus(0, 1, 32'h8401_FFFD, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 16'hFFFD, 0, 26'h0);
    checkOutput("t2_pc", pc_out, 32'd10);
    checkOutput("t2_cnt", instr_count, 32'd2);

    // Instruction at 10 jumps to 18
    applyStimulus(0, 1, 32'h0400_0007, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 16'h0, 1, 26'd7);

    // J at 18 with a taken branch alongside: jump wins
    applyStimulus(0, 1, 32'h0400_0002, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("t3_irpc", ir_pc, 32'd18);
    applyStimulus(0, 0, 32'h0, 1, 1, 16'h0040, 1, 26'd2);
    checkOutput("t3_pc", pc_out, 32'd21);

    // Jump back 23 from 21 to land on 0xFFFFFFFF
    applyStimulus(0, 1, 32'h07FF_FFE9, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 16'h0, 1, 26'h3FF_FFE9);
    checkOutput("neg_jmp_pc", pc_out, 32'hFFFF_FFFF);

    // Sequential retirement at the top of the address space wraps to 0
    applyStimulus(0, 1, 32'h1234_5678, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("t4_irpc", ir_pc, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 32'h0, 1, 0, 16'h0, 0, 26'h0);
    checkOutput("t4_pc", pc_out, 32'd0);

    // Reset while holding a valid instruction
    applyStimulus(0, 1, 32'h1111_2222, 0, 0, 16'h0, 0, 26'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("t6_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("t6_cnt", instr_count, 32'd0);

    // NOOP halts; everything is then frozen until reset
    applyStimulus(0, 1, 32'h0, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("t5_halted", {31'd0, halted}, 32'd1);
    applyStimulus(0, 1, 32'hABCD_0001, 1, 1, 16'h0004, 1, 26'd9);
    applyStimulus(0, 0, 32'h0, 1, 0, 16'h0, 0, 26'h0);
    checkOutput("t5_frozen_pc", pc_out, 32'd1);
    applyStimulus(1, 0, 32'h0, 0, 0, 16'h0, 0, 26'h0);
    checkOutput("t5_rst_halted", {31'd0, halted}, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), 
                    ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom),
                    1'($urandom), 1'($urandom), 16'($urandom),
                    1'($urandom), 26'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
